// File: rtl/ecp5pll_phase_pkg.sv
// Shared constants for the ECP5 PLL dynamic phase sequencer.
// Holds the FSM state encoding, the default timing values and a small
// helper used to size the shared step timer.
package ecp5pll_phase_pkg;

    // Default timing, in clk cycles
    localparam int C_DEF_PHASE_BITS   = 8;
    localparam int C_DEF_SETUP_CYCLES = 2;
    localparam int C_DEF_PULSE_CYCLES = 4;
    localparam int C_DEF_GAP_CYCLES   = 4;

    // Sequencer states; S_LOAD is only reachable when the load feature is built in
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_LOAD  = 3'd5;

    // Largest of three cycle counts, used to size the step timer
    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ecp5pll_phase_timer.sv
// Loadable down-counter with a zero flag. One instance times every
// SETUP, PULSE, GAP and LOAD interval of the phase sequencer: loading
// N-1 on state entry makes the flag rise in the state's last cycle.
module ecp5pll_phase_timer #(
    parameter int C_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [C_WIDTH-1:0] value,
    output logic               zero
);

    logic [C_WIDTH-1:0] count;

    // Load on request, otherwise count down and park at zero
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - C_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ecp5pll_phase_seq.sv
// ECP5 EHXPLLL dynamic phase sequencer. Accepts an absolute target phase,
// picks the shorter direction around the modulo-2^C_PHASE_BITS ring and
// emits timed phasestep pulses until the tracked phase reaches the target.
// Optional feature: define ECP5PLL_PHASE_LOADREG_EN to add the LOAD state,
// which pulses phaseloadreg on load_req and clears the tracked phase.
module ecp5pll_phase_seq
    import ecp5pll_phase_pkg::*;
#(
    parameter int C_PHASE_BITS   = C_DEF_PHASE_BITS,
    parameter int C_SETUP_CYCLES = C_DEF_SETUP_CYCLES,
    parameter int C_PULSE_CYCLES = C_DEF_PULSE_CYCLES,
    parameter int C_GAP_CYCLES   = C_DEF_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [C_PHASE_BITS-1:0] cmd_target,
    input  logic                    load_req,
    output logic [C_PHASE_BITS-1:0] phase,
    output logic                    busy,
    output logic                    done,
    output logic                    phasedir,
    output logic                    phasestep,
    output logic                    phaseloadreg
);

    localparam int C_TIMER_BITS =
        $clog2(max_of3(C_SETUP_CYCLES, C_PULSE_CYCLES, C_GAP_CYCLES) + 1);

    localparam logic [C_TIMER_BITS-1:0] C_SETUP_LOAD = C_TIMER_BITS'(C_SETUP_CYCLES - 1);
    localparam logic [C_TIMER_BITS-1:0] C_PULSE_LOAD = C_TIMER_BITS'(C_PULSE_CYCLES - 1);
    localparam logic [C_TIMER_BITS-1:0] C_GAP_LOAD   = C_TIMER_BITS'(C_GAP_CYCLES - 1);

    // Half the ring; a distance of exactly half is taken upwards
    localparam logic [C_PHASE_BITS-1:0] C_HALF = {1'b1, {(C_PHASE_BITS-1){1'b0}}};

    logic [2:0]              state;
    logic [2:0]              next_state;
    logic [C_PHASE_BITS-1:0] target;
    logic [C_PHASE_BITS-1:0] diff;
    logic                    timer_load;
    logic [C_TIMER_BITS-1:0] timer_value;
    logic                    timer_zero;

    ecp5pll_phase_timer #(
        .C_WIDTH (C_TIMER_BITS)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    // Next-state decode and timer reload for the state being entered
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        diff        = cmd_target - phase;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (diff == '0) begin
                        next_state = S_DONE;
                    end else begin
                        next_state  = S_SETUP;
                        timer_load  = 1'b1;
                        timer_value = C_SETUP_LOAD;
                    end
                end
`ifdef ECP5PLL_PHASE_LOADREG_EN
                else if (load_req) begin
                    next_state  = S_LOAD;
                    timer_load  = 1'b1;
                    timer_value = C_PULSE_LOAD;
                end
`endif
            end
            S_SETUP: begin
                if (timer_zero) begin
                    next_state  = S_PULSE;
                    timer_load  = 1'b1;
                    timer_value = C_PULSE_LOAD;
                end
            end
            S_PULSE: begin
                if (timer_zero) begin
                    next_state  = S_GAP;
                    timer_load  = 1'b1;
                    timer_value = C_GAP_LOAD;
                end
            end
            S_GAP: begin
                if (timer_zero) begin
                    if (phase == target) begin
                        next_state = S_DONE;
                    end else begin
                        next_state  = S_SETUP;
                        timer_load  = 1'b1;
                        timer_value = C_SETUP_LOAD;
                    end
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
`ifdef ECP5PLL_PHASE_LOADREG_EN
            S_LOAD: begin
                if (timer_zero) begin
                    next_state = S_DONE;
                end
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State, tracked phase, latched command and registered PLL controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            phase     <= '0;
            target    <= '0;
            phasedir  <= 1'b0;
            phasestep <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            phasestep <= (next_state == S_PULSE);
            done      <= (next_state == S_DONE);
            if (state == S_IDLE && cmd_valid) begin
                target   <= cmd_target;
                phasedir <= (diff <= C_HALF);
            end
            if (state == S_PULSE && timer_zero) begin
                phase <= phasedir ? phase + C_PHASE_BITS'(1) : phase - C_PHASE_BITS'(1);
            end
`ifdef ECP5PLL_PHASE_LOADREG_EN
            if (state == S_LOAD && timer_zero) begin
                phase <= '0;
            end
`endif
        end
    end

`ifdef ECP5PLL_PHASE_LOADREG_EN
    // Phase-register load strobe, high for the whole LOAD interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phaseloadreg <= 1'b0;
        end else begin
            phaseloadreg <= (next_state == S_LOAD);
        end
    end
`else
    logic unused_load_req;
    assign unused_load_req = load_req;
    assign phaseloadreg    = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ecp5pll_phase_seq.sv
// Directed testbench for ecp5pll_phase_seq with default parameters.
// Build with ECP5PLL_PHASE_LOADREG_EN defined to exercise the LOAD path.
// Cycle 0 is the cycle in which cmd_valid (or load_req) is presented;
// outputs are sampled on the falling edge of each cycle.
module tb_ecp5pll_phase_seq;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic       load_req;
    logic [7:0] phase;
    logic       busy;
    logic       done;
    logic       phasedir;
    logic       phasestep;
    logic       phaseloadreg;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the most recent run_cmd
    int   starts[$];
    int   done_cyc;
    bit   width_bad;
    bit   dir_changed;
    logic dir_first;
    logic ready_at_accept;

    ecp5pll_phase_seq dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .load_req     (load_req),
        .phase        (phase),
        .busy         (busy),
        .done         (done),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        load_req  = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Present one command and watch until done or the cycle budget runs out.
    // With poke set, cmd_valid is raised again mid-sequence with another target.
    task automatic run_cmd(input logic [7:0] tgt, input int budget, input bit poke);
        bit prev_step;
        int width;
        starts.delete();
        done_cyc    = -1;
        width_bad   = 1'b0;
        dir_changed = 1'b0;
        prev_step   = 1'b0;
        width       = 0;
        @(negedge clk);
        cmd_valid       = 1'b1;
        cmd_target      = tgt;
        ready_at_accept = cmd_ready;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_valid = 1'b0;
                dir_first = phasedir;
            end
            if (poke && c == 50) begin
                cmd_valid  = 1'b1;
                cmd_target = 8'h10;
            end
            if (poke && c == 52) cmd_valid = 1'b0;
            if (phasedir !== dir_first) dir_changed = 1'b1;
            if (phasestep && !prev_step) begin
                starts.push_back(c);
                width = 0;
            end
            if (phasestep) width++;
            if (!phasestep && prev_step && width != 4) width_bad = 1'b1;
            prev_step = phasestep;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    // Cycle after done: back in IDLE with done already low
    task automatic check_after_done(input string tag);
        @(negedge clk);
        check({tag, "_ready_after"}, cmd_ready, 1);
        check({tag, "_done_low_after"}, done, 0);
    endtask

    initial begin
        int hi;
        int first_hi;
        int load_done;
        int busy_seen;

        cmd_target = '0;
        cmd_valid  = 1'b0;
        load_req   = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_phasedir", phasedir, 0);
        check("rst_phasestep", phasestep, 0);
        check("rst_phaseloadreg", phaseloadreg, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Target equal to current phase: immediate done, no pulses
        run_cmd(8'd0, 20, 1'b0);
        check("zero_ready_accept", ready_at_accept, 1);
        check("zero_done_cycle", done_cyc, 1);
        check("zero_pulses", starts.size(), 0);
        check_after_done("zero");

        // 0 -> 3: three pulses upwards
        run_cmd(8'd3, 100, 1'b0);
        check("up3_dir", dir_first, 1);
        check("up3_dir_stable", dir_changed, 0);
        check("up3_pulses", starts.size(), 3);
        if (starts.size() == 3) begin
            check("up3_start0", starts[0], 3);
            check("up3_start1", starts[1], 13);
            check("up3_start2", starts[2], 23);
        end
        check("up3_width", width_bad, 0);
        check("up3_done_cycle", done_cyc, 31);
        check("up3_phase", phase, 3);
        check_after_done("up3");

        // Wrap boundaries: 0 -> 255 goes down, 255 -> 0 goes up
        do_reset();
        run_cmd(8'd255, 100, 1'b0);
        check("dn255_dir", dir_first, 0);
        check("dn255_pulses", starts.size(), 1);
        check("dn255_done_cycle", done_cyc, 11);
        check("dn255_phase", phase, 255);
        check_after_done("dn255");
        run_cmd(8'd0, 100, 1'b0);
        check("wrap0_dir", dir_first, 1);
        check("wrap0_pulses", starts.size(), 1);
        check("wrap0_phase", phase, 0);
        check_after_done("wrap0");

        // Exactly half way round: tie goes up; mid-sequence cmd_valid is ignored
        run_cmd(8'd128, 2000, 1'b1);
        check("half_dir", dir_first, 1);
        check("half_dir_stable", dir_changed, 0);
        check("half_pulses", starts.size(), 128);
        check("half_width", width_bad, 0);
        check("half_done_cycle", done_cyc, 1281);
        check("half_phase", phase, 128);
        check_after_done("half");

        // Reset during the second PULSE cycle of a 0 -> 5 sequence
        do_reset();
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 8'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_step_c3", phasestep, 1);
        @(posedge clk);
        #2;
        check("rstmid_step_c4", phasestep, 1);
        reset = 1'b1;
        #1;
        check("rstmid_step_drop", phasestep, 0);
        check("rstmid_phase", phase, 0);
        check("rstmid_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_ready_after", cmd_ready, 1);
        check("rstmid_phase_after", phase, 0);
        check("rstmid_step_after", phasestep, 0);

        // Phase-register load from phase 7
        run_cmd(8'd7, 200, 1'b0);
        check("load_pre_phase", phase, 7);
        @(negedge clk);
        hi        = 0;
        first_hi  = -1;
        load_done = -1;
        busy_seen = 0;
        @(negedge clk);
        load_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            load_req = 1'b0;
            if (phaseloadreg) begin
                hi++;
                if (first_hi < 0) first_hi = c;
            end
            if (busy) busy_seen++;
            if (done && load_done < 0) load_done = c;
        end
`ifdef ECP5PLL_PHASE_LOADREG_EN
        check("load_hi_cycles", hi, 4);
        check("load_first_hi", first_hi, 1);
        check("load_done_cycle", load_done, 5);
        check("load_phase", phase, 0);
        check("load_ready_after", cmd_ready, 1);
`else
        check("noload_hi_cycles", hi, 0);
        check("noload_busy", busy_seen, 0);
        check("noload_done", load_done, -1);
        check("noload_phase", phase, 7);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
